// File: rtl/mem_pkg.sv
// Shared types for the backing main memory: access FSM states and the
// four-byte little-endian word carried on the cache memory port.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } mem_state_t;

   // Element [k] is the byte at address base+k.
   typedef logic [0:WORD_BYTES-1][7:0] byte_word_t;

endpackage

// File: rtl/byte_ram.sv
// Byte-organised single-port storage with four byte lanes: synchronous
// word write on a strobe, combinational word read.
module byte_ram
   import mem_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [ADDR_BITS-3:0] word_i,
   input  byte_word_t           wdata_i,
   output byte_word_t           rdata_o
);

   logic [7:0] mem_q [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            mem_q[{word_i, 2'(k)}] <= wdata_i[k];
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
         rdata_o[k] = mem_q[{word_i, 2'(k)}];
      end
   end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory behind the cache controller: one word access at
// a time, IDLE -> WAIT (latency countdown) -> DONE (one-cycle ready pulse).
module main_memory
   import mem_pkg::*;
#(
   parameter int ADDR_BITS = 12,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_write_en,
   input  byte_word_t  mem_data_in,
   output byte_word_t  mem_data_out,
   output logic        mem_ready,
   output logic        busy
);

   if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("main_memory: LATENCY must be in 1..255");
   end

   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   mem_state_t           state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-3:0] addr_q, addr_d;
   logic                 we_q, we_d;
   byte_word_t           wdata_q, wdata_d;
   byte_word_t           rdata_q, rdata_d;
   logic                 ram_we;
   byte_word_t           ram_rdata;

   // Byte-offset bits and bits above the decoded range are dropped on purpose.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

   byte_ram #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .clk    (clk),
      .we_i   (ram_we),
      .word_i (addr_q),
      .wdata_i(wdata_q),
      .rdata_o(ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ram_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req) begin
               state_d = WAIT;
               cnt_d   = CNT_INIT;
               addr_d  = mem_addr[ADDR_BITS-1:2];
               we_d    = mem_write_en;
               wdata_d = mem_data_in;
            end
         end
         WAIT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               // Access edge: the write strobe and read capture share this edge.
               state_d = DONE;
               if (we_q) ram_we = 1'b1;
               else      rdata_d = ram_rdata;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_data_out = rdata_q;
   assign mem_ready    = (state_q == DONE);
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: vector table on a LATENCY=4 instance plus
// hand sequences for held requests, reset aborts and a LATENCY=1 instance.
module tb_main_memory;
   import mem_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic        req = 1'b0, we = 1'b0, rdy, bsy;
   logic [31:0] addr = '0;
   byte_word_t  din = '0, dout;

   logic        req1 = 1'b0, we1 = 1'b0, rdy1, bsy1;
   logic [31:0] addr1 = '0;
   byte_word_t  din1 = '0, dout1;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[11];

   main_memory #(.ADDR_BITS(12), .LATENCY(4)) dut (
      .clk(clk), .rst(rst), .mem_req(req), .mem_addr(addr),
      .mem_write_en(we), .mem_data_in(din), .mem_data_out(dout),
      .mem_ready(rdy), .busy(bsy)
   );

   main_memory #(.ADDR_BITS(12), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .mem_req(req1), .mem_addr(addr1),
      .mem_write_en(we1), .mem_data_in(din1), .mem_data_out(dout1),
      .mem_ready(rdy1), .busy(bsy1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full access on the LATENCY=4 instance; returns edges from accept to ready.
   task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rd);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; din = d;
      @(posedge clk); #1;
      req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; din = 32'hA5A5_A5A5;
      check("busy_after_accept", 32'(bsy), 32'd1);
      lat = -1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (rdy) begin
            lat = i;
            break;
         end
      end
      rd = dout;
      @(posedge clk); #1;
      check("ready_width", 32'(rdy), 32'd0);
      check("idle_after_done", 32'(bsy), 32'd0);
   endtask

   initial begin
      int lat;
      logic [31:0] rd;
      logic [31:0] exp_w;
      logic exp_r, exp_b;

      vecs[0]  = '{1'b1, 32'h0000_0100, 32'h1122_3344, 32'h0000_0000};
      vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h1122_3344};
      vecs[2]  = '{1'b0, 32'h0000_0103, 32'h0,         32'h1122_3344};
      vecs[3]  = '{1'b0, 32'h0000_1100, 32'h0,         32'h1122_3344};
      vecs[4]  = '{1'b1, 32'h0000_0204, 32'h5566_7788, 32'h1122_3344};
      vecs[5]  = '{1'b0, 32'h0000_0207, 32'h0,         32'h5566_7788};
      vecs[6]  = '{1'b1, 32'h0000_0FFE, 32'hDEAD_BEEF, 32'h5566_7788};
      vecs[7]  = '{1'b0, 32'h0000_7FFC, 32'h0,         32'hDEAD_BEEF};
      vecs[8]  = '{1'b0, 32'h0000_0101, 32'h0,         32'h1122_3344};
      vecs[9]  = '{1'b1, 32'h0000_0200, 32'h0102_0304, 32'h1122_3344};
      vecs[10] = '{1'b0, 32'h0000_0200, 32'h0,         32'h0102_0304};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_ready", 32'(rdy), 32'd0);
      check("reset_busy", 32'(bsy), 32'd0);
      check("reset_data", dout, 32'h0);

      // Vector table
      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i].exp_rd);
         do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
         exp_w = exp_q.pop_front();
         check($sformatf("vec%0d_data", i), rd, exp_w);
      end

      // Request held high: accepted at edges 1, 7, 13, 19
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h0000_0100;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         exp_r = (i >= 5) && ((i - 5) % 6 == 0);
         exp_b = (i % 6 != 0);
         check($sformatf("held_ready_%0d", i), 32'(rdy), 32'(exp_r));
         check($sformatf("held_busy_%0d", i), 32'(bsy), 32'(exp_b));
      end
      req = 1'b0;
      for (int i = 0; i < 50 && bsy; i++) begin
         @(posedge clk); #1;
      end
      check("held_drain", 32'(bsy), 32'd0);

      // Reset during WAIT aborts a write of 0xAA x4 to 0x200
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h0000_0200; din = 32'hAAAA_AAAA;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      check("wait_busy_before_rst", 32'(bsy), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_wait_busy", 32'(bsy), 32'd0);
      check("rst_wait_ready", 32'(rdy), 32'd0);
      check("rst_wait_data", dout, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("no_ready_after_abort", 32'(rdy), 32'd0);
      end
      do_access(1'b0, 32'h0000_0200, 32'h0, lat, rd);
      check("abort_read_lat", 32'(lat), 32'd4);
      check("abort_read_data", rd, 32'h0102_0304);

      // Reset during DONE cuts the ready pulse
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h0000_0100;
      @(posedge clk); #1;
      req = 1'b0;
      lat = -1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (rdy) begin
            lat = i;
            break;
         end
      end
      check("done_rst_lat", 32'(lat), 32'd4);
      check("done_rst_data_before", dout, 32'h1122_3344);
      rst = 1'b1;
      #1;
      check("rst_done_ready", 32'(rdy), 32'd0);
      check("rst_done_data", dout, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_done_busy", 32'(bsy), 32'd0);
      check("rst_done_ready_after", 32'(rdy), 32'd0);

      // LATENCY=1 instance: write then held read
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0100; din1 = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req1 = 1'b0; din1 = 32'h0;
      check("l1_w_busy", 32'(bsy1), 32'd1);
      check("l1_w_ready_early", 32'(rdy1), 32'd0);
      @(posedge clk); #1;
      check("l1_w_ready", 32'(rdy1), 32'd1);
      check("l1_w_data_unchanged", dout1, 32'h0);
      @(posedge clk); #1;
      check("l1_w_idle", 32'(bsy1), 32'd0);

      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0103;
      @(posedge clk); #1;
      check("l1_r_busy", 32'(bsy1), 32'd1);
      check("l1_r_ready_early", 32'(rdy1), 32'd0);
      @(posedge clk); #1;
      check("l1_r_ready", 32'(rdy1), 32'd1);
      check("l1_r_data", dout1, 32'hCAFE_F00D);
      @(posedge clk); #1;
      check("l1_not_accepted_in_done", 32'(bsy1), 32'd0);
      check("l1_ready_width", 32'(rdy1), 32'd0);
      @(posedge clk); #1;
      check("l1_reaccept", 32'(bsy1), 32'd1);
      req1 = 1'b0;
      @(posedge clk); #1;
      check("l1_second_ready", 32'(rdy1), 32'd1);
      @(posedge clk); #1;
      check("l1_final_idle", 32'(bsy1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/main_memory.md
# main_memory

Backing main memory downstream of the memory stage's cache controller. It accepts one word-wide read or write request at a time over the cache's memory port. Each access completes after a fixed, parameterised latency and is acknowledged with a one-cycle ready pulse. Storage is byte-organised and little-endian, and words are carried as four-byte arrays.

## Interface

Parameters:
- ADDR_BITS, default 12: byte-address bits decoded, giving 2^ADDR_BITS bytes of storage.
- LATENCY, default 4: cycles from request acceptance to the access edge. Legal range is 1..255; elaboration fails outside it.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- mem_req, input, 1: request strobe, sampled only in IDLE.
- mem_addr, input, 32: byte address of the word to access.
- mem_write_en, input, 1: 1 = write, 0 = read; sampled with mem_req.
- mem_data_in, input, 8 x [0:3]: write data; byte k goes to address base+k.
- mem_data_out, output, 8 x [0:3]: read data; byte k is from address base+k.
- mem_ready, output, 1: one-cycle completion pulse for both reads and writes.
- busy, output, 1: high whenever state is not IDLE.

## Operation

- States:
  - IDLE: waits for a request.
  - WAIT: latency countdown.
  - DONE: acknowledge cycle.
- IDLE: when mem_req = 1, the block does the following, then moves to WAIT:
  - latches addr, we and data;
  - loads cnt = LATENCY-1.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the access and move to DONE.
- DONE: mem_ready = 1 for exactly this cycle, then unconditionally return to IDLE.
- Address handling:
  - base = {addr[ADDR_BITS-1:2], 2'b00}.
  - addr[1:0] is ignored, so accesses are word-aligned.
  - Bits above ADDR_BITS-1 are ignored; the memory aliases modulo 2^ADDR_BITS.
- Write access: all four latched bytes are stored at base..base+3 on the access edge. mem_data_out is unchanged.
- Read access: mem_data_out is loaded from base..base+3 on the access edge. It holds that value until the next read completes or until reset.
- mem_req in WAIT or DONE is ignored and is not queued. The requester must hold or re-issue mem_req after seeing mem_ready.
- Changes to mem_addr, mem_write_en or mem_data_in after acceptance have no effect.

## Timing

- Request accepted at edge t0: the access happens at edge t0+LATENCY, and mem_ready is high in the cycle after that edge.
- Read data is valid in the same cycle as mem_ready.
- busy rises in the cycle after t0 and falls in the cycle after the DONE cycle.
- Throughput: at most one access per LATENCY+2 cycles. A request held continuously high is re-accepted on the first IDLE cycle.
- Reset values:
  - state = IDLE, cnt = 0;
  - mem_ready = 0, busy = 0;
  - mem_data_out = all bytes 0x00;
  - latched request registers = 0.
- Storage contents are not reset.
- Reset in WAIT aborts the access: no write is performed and no ready is issued.
- Reset in DONE suppresses the remainder of the ready pulse.
- LATENCY = 1: the access happens on the first WAIT edge, and mem_ready appears two cycles after the accepting edge's cycle.

## Structure

- Package mem_pkg holds:
  - typedef mem_state_t (IDLE, WAIT, DONE);
  - typedef byte_word_t, an array of 4 x 8 bits;
  - localparam WORD_BYTES = 4.
- Sub-module byte_ram holds the storage. It is a 2^ADDR_BITS x 8 array with a single port and four byte lanes. Its write is synchronous on a write strobe; its read is combinational and gets registered into mem_data_out by the parent.
- The top holds the FSM, the latency counter and the request latch.

## Test plan

- Write 0x11,0x22,0x33,0x44 to addr 0x100, then read 0x100 -> each mem_ready comes exactly LATENCY cycles after acceptance, and the read returns [0]=0x11 … [3]=0x44.
- Read 0x103 after that write -> same bytes as from 0x100, because the low bits are ignored.
- Read addr 0x00001100 with ADDR_BITS = 12 -> aliases to 0x100 and returns 0x11,0x22,0x33,0x44.
- mem_req held high for 20 cycles with LATENCY = 4 -> accesses are accepted every 6 cycles, and mem_ready pulses are 1 cycle wide.
- Write 0xAA×4 to 0x200, then assert rst during WAIT -> busy = 0, mem_ready = 0 and mem_data_out = 0; a later read of 0x200 does not return 0xAA.
- LATENCY = 1 build: read 0x100 -> mem_ready 1 cycle after acceptance, and no request is accepted while busy = 1.
